// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the FSM state type.
// The control FSM uses the same encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_MULU = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;

  typedef enum logic {IDLE, CALC} aluState_e;

  function automatic logic isIterOp(input logic [3:0] op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per step.
// hi/lo present the post-step values so the caller can capture the final result.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [CNT_W-1:0] count;
  logic             isDiv;
  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] shiftLo;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] nextHi;
  logic [WIDTH-1:0] nextLo;

  // Multiply shifts the product right through accHi:shiftLo; divide shifts the
  // dividend left into the remainder and keeps the difference when no borrow occurs.
  always_comb begin
    mulSum   = {1'b0, accHi} + (shiftLo[0] ? {1'b0, operandB} : '0);
    divTrial = {accHi, shiftLo[WIDTH-1]} - {1'b0, operandB};
    if (isDiv) begin
      if (!divTrial[WIDTH]) begin
        nextHi = divTrial[WIDTH-1:0];
        nextLo = {shiftLo[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = {accHi[WIDTH-2:0], shiftLo[WIDTH-1]};
        nextLo = {shiftLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi = mulSum[WIDTH:1];
      nextLo = {mulSum[0], shiftLo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count    <= '0;
      isDiv    <= 1'b0;
      operandB <= '0;
      accHi    <= '0;
      shiftLo  <= '0;
    end else if (load) begin
      count    <= '0;
      isDiv    <= op_is_div;
      operandB <= b;
      accHi    <= '0;
      shiftLo  <= a;
    end else if (step) begin
      count    <= count + 1'b1;
      accHi    <= nextHi;
      shiftLo  <= nextLo;
    end
  end

  assign last = (count == '1);
  assign hi   = nextHi;
  assign lo   = nextLo;

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle ops with registered results, plus iterative
// MULU/DIVU driven through a Start/Busy/Done handshake.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] AIn,
  input  logic [WIDTH-1:0] BMuxOut,
  input  logic [3:0]       ALUOp,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUHi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  aluState_e        state, nextState;
  logic             iterReq;
  logic             iterLoad, iterStep, iterLast, iterFire, singleFire;
  logic [WIDTH-1:0] iterHi, iterLo;
  logic [WIDTH-1:0] singleOut, singleHi;
  logic             singleDbz;
  logic [CNT_W-1:0] shamt;

  // DIVU by zero is resolved immediately instead of iterating.
  assign iterReq = isIterOp(ALUOp) && !((ALUOp == ALU_DIVU) && (BMuxOut == '0));

  always_comb begin
    singleOut = '0;
    singleHi  = '0;
    singleDbz = 1'b0;
    shamt     = BMuxOut[CNT_W-1:0];
    case (ALUOp)
      ALU_ADD: singleOut = AIn + BMuxOut;
      ALU_SUB: singleOut = AIn - BMuxOut;
      ALU_AND: singleOut = AIn & BMuxOut;
      ALU_OR:  singleOut = AIn | BMuxOut;
      ALU_XOR: singleOut = AIn ^ BMuxOut;
      ALU_SLT: singleOut = {{(WIDTH-1){1'b0}}, ($signed(AIn) < $signed(BMuxOut))};
      ALU_SLL: singleOut = AIn << shamt;
      ALU_SRL: singleOut = AIn >> shamt;
      ALU_SRA: singleOut = WIDTH'($signed(AIn) >>> shamt);
      ALU_DIVU: begin
        singleOut = '1;
        singleHi  = AIn;
        singleDbz = 1'b1;
      end
      default: singleOut = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start && iterReq) nextState = CALC;
      CALC:    if (iterLast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy       = 1'b0;
    iterLoad   = 1'b0;
    iterStep   = 1'b0;
    iterFire   = 1'b0;
    singleFire = 1'b0;
    case (state)
      IDLE: begin
        iterLoad   = Start && iterReq;
        singleFire = Start && !iterReq;
      end
      CALC: begin
        Busy     = 1'b1;
        iterStep = 1'b1;
        iterFire = iterLast;
      end
      default: ;
    endcase
  end

  mul_div_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) iterUnit (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (iterLoad),
    .op_is_div(ALUOp == ALU_DIVU),
    .a        (AIn),
    .b        (BMuxOut),
    .step     (iterStep),
    .last     (iterLast),
    .hi       (iterHi),
    .lo       (iterLo)
  );

  // Results, flags and the Done pulse all change together at a completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ALUOut    <= '0;
      ALUHi     <= '0;
      Zero      <= 1'b1;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= singleFire || iterFire;
      if (singleFire) begin
        ALUOut    <= singleOut;
        ALUHi     <= singleHi;
        Zero      <= (singleOut == '0);
        DivByZero <= singleDbz;
      end else if (iterFire) begin
        ALUOut    <= iterLo;
        ALUHi     <= iterHi;
        Zero      <= (iterLo == '0);
        DivByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: stimulus pushes expected results and completion
// cycles, a negedge monitor pops and compares on every Done pulse.
module tb_alu_iter;
  import alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] AIn = '0;
  logic [31:0] BMuxOut = '0;
  logic [3:0]  ALUOp = '0;
  logic        Start = 1'b0;
  logic [31:0] ALUOut, ALUHi;
  logic        Zero, Busy, Done, DivByZero;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        dbz;
    int          doneAt;
  } expect_t;

  expect_t sb[$];
  int      cyc = 0;
  int      errors = 0;
  int      checks = 0;
  int      kEdge;

  alu_iter dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .AIn      (AIn),
    .BMuxOut  (BMuxOut),
    .ALUOp    (ALUOp),
    .Start    (Start),
    .ALUOut   (ALUOut),
    .ALUHi    (ALUHi),
    .Zero     (Zero),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest expectation, including its cycle.
  always @(negedge Clk) begin
    if (Reset_n && Done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 32'(cyc), 32'hFFFFFFFF);
      end else begin
        expect_t e;
        e = sb.pop_front();
        checkOutput({e.name, ".cycle"}, 32'(cyc), 32'(e.doneAt));
        checkOutput({e.name, ".out"}, ALUOut, e.out);
        checkOutput({e.name, ".hi"}, ALUHi, e.hi);
        checkOutput({e.name, ".zero"}, {31'b0, Zero}, {31'b0, e.zero});
        checkOutput({e.name, ".dbz"}, {31'b0, DivByZero}, {31'b0, e.dbz});
      end
    end
  end

  // Called at a negedge; Start is sampled at the next posedge.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expOut,
                               input logic [31:0] expHi, input logic expZero,
                               input logic expDbz, input int latency);
    expect_t e;
    ALUOp   = op;
    AIn     = a;
    BMuxOut = b;
    Start   = 1'b1;
    e.name  = name;
    e.out   = expOut;
    e.hi    = expHi;
    e.zero  = expZero;
    e.dbz   = expDbz;
    e.doneAt = cyc + 1 + latency;
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (sb.size() != 0 && n < maxCycles) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("doneTimeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge Clk);
    checkOutput("resetOut", ALUOut, 32'h0);
    checkOutput("resetZero", {31'b0, Zero}, 32'd1);
    checkOutput("resetBusy", {31'b0, Busy}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    applyStimulus("addWrap", ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    waitIdle(5);
    applyStimulus("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("slt", ALU_SLT, 32'h80000000, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("sra", ALU_SRA, 32'h80000000, 32'h24, 32'hF8000000, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("and", ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("or", ALU_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("xor", ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("sll", ALU_SLL, 32'h1, 32'h3F, 32'h80000000, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("srl", ALU_SRL, 32'h80000000, 32'h21, 32'h40000000, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);
    applyStimulus("reserved", 4'b1011, 32'd5, 32'd3, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    waitIdle(5);
    applyStimulus("muluSmall", ALU_MULU, 32'd3, 32'd5, 32'd15, 32'h0, 1'b0, 1'b0, 32);
    waitIdle(40);
    applyStimulus("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32);
    waitIdle(40);
    applyStimulus("divZero", ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b1, 0);
    waitIdle(5);
    applyStimulus("addClrDbz", ALU_ADD, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);

    // MULU with an ignored Start mid-iteration, then DIVU back-to-back in its Done cycle.
    kEdge = cyc + 1;
    applyStimulus("muluMax", ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE,
                  1'b0, 1'b0, 32);
    checkOutput("mulBusyFirst", {31'b0, Busy}, 32'd1);
    repeat (4) @(negedge Clk);
    ALUOp = ALU_ADD; AIn = 32'd1; BMuxOut = 32'd1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (26) @(negedge Clk);
    checkOutput("mulBusyLast", {31'b0, Busy}, 32'd1);
    @(negedge Clk);
    checkOutput("mulBusyDone", {31'b0, Busy}, 32'd0);
    checkOutput("mulDoneEdge", 32'(cyc), 32'(kEdge + 32));
    applyStimulus("divuB2B", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32);
    for (int i = 0; i < 6; i++) begin
      AIn = 32'h1234_0000 + 32'(i); BMuxOut = 32'(i); ALUOp = ALU_SUB;
      if (i == 2) Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
    end
    waitIdle(40);

    // Reset during iteration 10 of a MULU: no Done, outputs back to reset values.
    applyStimulus("muluAbort", ALU_MULU, 32'd7, 32'd9, 32'd63, 32'h0, 1'b0, 1'b0, 32);
    repeat (10) @(negedge Clk);
    Reset_n = 1'b0;
    sb.delete();
    #2;
    checkOutput("abortOut", ALUOut, 32'h0);
    checkOutput("abortHi", ALUHi, 32'h0);
    checkOutput("abortZero", {31'b0, Zero}, 32'd1);
    checkOutput("abortBusy", {31'b0, Busy}, 32'd0);
    checkOutput("abortDone", {31'b0, Done}, 32'd0);
    checkOutput("abortDbz", {31'b0, DivByZero}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (40) @(negedge Clk);
    checkOutput("afterAbortBusy", {31'b0, Busy}, 32'd0);
    applyStimulus("addAfterReset", ALU_ADD, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0, 0);
    waitIdle(5);

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Execute-stage ALU sitting directly downstream of the B-operand mux.
- Consumes operand A from the register-file/PC path and the selected B operand (register data, constant, or immediate).
- Single-cycle logic/arithmetic ops complete with registered latency 1.
- Unsigned multiply and divide run iteratively, one bit per cycle, under a Start/Busy/Done handshake read by the control FSM.

Parameters:
- WIDTH, 32: operand and result width.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- Clk, input, 1: rising-edge clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- AIn, input, WIDTH: operand A.
- BMuxOut, input, WIDTH: operand B from the B-operand mux.
- ALUOp, input, 4: operation select.
- Start, input, 1: begin operation; sampled only in IDLE.
- ALUOut, output, WIDTH: result low word (MULU low product, DIVU quotient).
- ALUHi, output, WIDTH: MULU high product or DIVU remainder; 0 for single-cycle ops.
- Zero, output, 1: registered flag, ALUOut == 0.
- Busy, output, 1: high while iterating.
- Done, output, 1: one-cycle pulse when results update.
- DivByZero, output, 1: registered; set on DIVU with B = 0, cleared on any other completion.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - ALUOut = 0, ALUHi = 0, Zero = 1, Busy = 0, Done = 0, DivByZero = 0, counter = 0.
  - Reset mid-iteration aborts the operation; no Done pulse is produced.
- ALUOp encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed compare; result is 1 or 0.
  - 0110 SLL, 0111 SRL, 1000 SRA: shift amount is BMuxOut[4:0].
  - 1001 MULU, 1010 DIVU.
  - 1011 to 1111 reserved: result 0, behaves as a single-cycle op.
- ADD and SUB wrap modulo 2^WIDTH; no overflow output.
- FSM states: IDLE, CALC.
  - IDLE, Start=1, single-cycle op: registers load at edge k. Done = 1 during cycle k+1 only; state stays IDLE.
  - IDLE, Start=1, MULU or DIVU with B ≠ 0: latch AIn and BMuxOut, clear counter, go to CALC. Busy = 1 during cycles k+1 through k+32.
  - CALC: one iteration per edge; counter increments 0 to 31.
  - CALC, at the edge where counter = 31: write ALUOut/ALUHi/Zero, Busy = 0, Done = 1 during cycle k+33, return to IDLE.
  - IDLE, Start=1, DIVU with B = 0: single-cycle result. ALUOut = all ones, ALUHi = AIn, DivByZero = 1.
- MULU: shift-add algorithm; produces the full 2*WIDTH-bit product.
- DIVU: restoring division; quotient goes to ALUOut, remainder to ALUHi.
- Operands are latched at Start. AIn, BMuxOut and ALUOp changes during CALC have no effect.
- Start while Busy is ignored; it is not queued.
- Start sampled in the same cycle Done is high is accepted, giving back-to-back ops.
- Outputs hold their last values between completions.
- Zero and DivByZero update only at completion, together with ALUOut.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default.
  - ALUOp encoding constants (ALU_ADD … ALU_DIVU).
  - FSM state enum (IDLE, CALC).
  - The same encodings are reused by the control FSM.
- One natural sub-module, mul_div_iter: owns the iteration counter, the product/remainder accumulator and the shift register. Interface: load, op_is_div, a, b, step, last, hi, lo.
- alu_iter keeps the combinational single-cycle datapath, the FSM and the output registers.

Test Plan:
- Reset: assert Reset_n=0 mid-MULU at iteration 10, release → all outputs at reset values, Busy=0, no Done pulse; next ADD works.
- ADD/SUB: Start ADD with A=0xFFFFFFFF, B=1 → ALUOut=0, Zero=1, Done one cycle after Start. Then SUB with A=5, B=7 → ALUOut=0xFFFFFFFE, Zero=0.
- SLT/SRA: SLT with A=0x80000000, B=1 → ALUOut=1. SRA with A=0x80000000, B=0x24 (shift 4) → ALUOut=0xF8000000.
- MULU: A=0xFFFFFFFF, B=0xFFFFFFFF → Busy for 32 cycles, Done in cycle k+33, ALUHi=0xFFFFFFFE, ALUOut=0x00000001. A Start pulse injected at cycle k+5 is ignored.
- DIVU: A=100, B=7 → ALUOut=14, ALUHi=2, DivByZero=0 after 33 cycles. Then A=9, B=0 → 1-cycle Done, ALUOut=0xFFFFFFFF, ALUHi=9, DivByZero=1.
- Back-to-back: Start DIVU (A=100, B=7) asserted in the Done cycle of a MULU → accepted, second Done 33 cycles later; AIn/BMuxOut toggled during CALC do not alter the result.
